// File: rtl/pixel_sequencer.sv
// Pixel array frame sequencer: erase, expose and ramp-convert the array, then
// hand each latched pixel code downstream over a valid/ready port.
module pixel_sequencer #(
  parameter int unsigned ADC_BITS     = 8,
  parameter int unsigned NUM_PIX      = 4,
  parameter int unsigned ERASE_CYCLES = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  input  logic [15:0]         expose_len,
  output logic                erase,
  output logic                expose,
  output logic                convert,
  output logic [ADC_BITS-1:0] ramp_code,
  output logic [NUM_PIX-1:0]  read_sel,
  input  logic [ADC_BITS-1:0] pixel_data,
  output logic [ADC_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                frame_done,
  output logic                busy
);
  localparam int unsigned EW        = (ERASE_CYCLES > 1) ? $clog2(ERASE_CYCLES) : 1;
  localparam int unsigned IW        = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int unsigned CW        = ADC_BITS + 1;
  localparam int unsigned CONV_LAST = (1 << ADC_BITS) - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_RD_SETUP, S_RD_XFER, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [EW-1:0]       erase_cnt_q, erase_cnt_d;
  logic [15:0]         exp_cnt_q, exp_cnt_d;
  logic [15:0]         exp_len_q, exp_len_d;
  logic [CW-1:0]       conv_cnt_q, conv_cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [ADC_BITS-1:0] ramp_d, out_data_d;
  logic [NUM_PIX-1:0]  read_sel_d;
  logic                erase_d, expose_d, convert_d, out_valid_d, frame_done_d, busy_d;

  // Next state, counters and next output values; outputs follow the next state
  always_comb begin
    state_d     = state_q;
    erase_cnt_d = erase_cnt_q;
    exp_cnt_d   = exp_cnt_q;
    exp_len_d   = exp_len_q;
    conv_cnt_d  = conv_cnt_q;
    idx_d       = idx_q;
    ramp_d      = ramp_code;
    out_data_d  = out_data;

    case (state_q)
      S_IDLE: begin
        if (start || continuous) begin
          state_d   = S_ERASE;
          exp_len_d = (expose_len == 16'd0) ? 16'd1 : expose_len;
          ramp_d    = '0;
        end
      end
      S_ERASE: begin
        if (erase_cnt_q == EW'(ERASE_CYCLES - 1)) begin
          state_d     = S_EXPOSE;
          erase_cnt_d = '0;
        end else begin
          erase_cnt_d = erase_cnt_q + EW'(1);
        end
      end
      S_EXPOSE: begin
        if (exp_cnt_q == exp_len_q - 16'd1) begin
          state_d   = S_CONVERT;
          exp_cnt_d = '0;
        end else begin
          exp_cnt_d = exp_cnt_q + 16'd1;
        end
      end
      S_CONVERT: begin
        // Ramp stops at all-ones on the last convert cycle and holds there
        if (conv_cnt_q == CW'(CONV_LAST)) begin
          state_d    = S_RD_SETUP;
          conv_cnt_d = '0;
          idx_d      = '0;
        end else begin
          conv_cnt_d = conv_cnt_q + CW'(1);
          ramp_d     = ramp_code + ADC_BITS'(1);
        end
      end
      S_RD_SETUP: begin
        out_data_d = pixel_data;
        state_d    = S_RD_XFER;
      end
      S_RD_XFER: begin
        if (out_ready) begin
          if (idx_q == IW'(NUM_PIX - 1)) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            state_d = S_RD_SETUP;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      S_DONE: begin
        if (continuous) begin
          state_d   = S_ERASE;
          exp_len_d = (expose_len == 16'd0) ? 16'd1 : expose_len;
          ramp_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    erase_d      = (state_d == S_ERASE);
    expose_d     = (state_d == S_EXPOSE);
    convert_d    = (state_d == S_CONVERT);
    out_valid_d  = (state_d == S_RD_XFER);
    frame_done_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
    read_sel_d   = (state_d == S_RD_SETUP || state_d == S_RD_XFER) ?
                   (NUM_PIX'(1) << idx_d) : '0;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      erase_cnt_q <= '0;
      exp_cnt_q   <= '0;
      exp_len_q   <= '0;
      conv_cnt_q  <= '0;
      idx_q       <= '0;
      ramp_code   <= '0;
      out_data    <= '0;
      read_sel    <= '0;
      erase       <= 1'b0;
      expose      <= 1'b0;
      convert     <= 1'b0;
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      erase_cnt_q <= erase_cnt_d;
      exp_cnt_q   <= exp_cnt_d;
      exp_len_q   <= exp_len_d;
      conv_cnt_q  <= conv_cnt_d;
      idx_q       <= idx_d;
      ramp_code   <= ramp_d;
      out_data    <= out_data_d;
      read_sel    <= read_sel_d;
      erase       <= erase_d;
      expose      <= expose_d;
      convert     <= convert_d;
      out_valid   <= out_valid_d;
      frame_done  <= frame_done_d;
      busy        <= busy_d;
    end
  end
endmodule

// File: tb/tb_pixel_sequencer.sv
// Scoreboard bench for pixel_sequencer: frame and pixel expectations are queued
// as stimulus is issued and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_pixel_sequencer;
  localparam int unsigned AB    = 8;
  localparam int unsigned NP    = 4;
  localparam int unsigned EC    = 5;
  localparam int unsigned NCONV = 1 << AB;
  localparam int unsigned SAB   = 4;
  localparam logic [NP-1:0] SEL2 = NP'(4);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, continuous;
  logic [15:0]   expose_len;
  logic          erase, expose, convert, out_valid, frame_done, busy;
  logic [AB-1:0] ramp_code, out_data;
  logic [AB-1:0] pixel_data = '0;
  logic          out_ready  = 1'b1;
  logic [NP-1:0] read_sel;

  logic           s_reset, s_start, s_continuous, s_out_ready;
  logic [15:0]    s_expose_len;
  logic           s_erase, s_expose, s_convert, s_out_valid, s_frame_done, s_busy;
  logic [SAB-1:0] s_ramp_code, s_pixel_data, s_out_data;
  logic [0:0]     s_read_sel;

  pixel_sequencer #(.ADC_BITS(AB), .NUM_PIX(NP), .ERASE_CYCLES(EC)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .expose_len(expose_len), .erase(erase), .expose(expose), .convert(convert),
    .ramp_code(ramp_code), .read_sel(read_sel), .pixel_data(pixel_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done), .busy(busy)
  );

  pixel_sequencer #(.ADC_BITS(SAB), .NUM_PIX(1), .ERASE_CYCLES(1)) dut_s (
    .clk(clk), .reset(s_reset), .start(s_start), .continuous(s_continuous),
    .expose_len(s_expose_len), .erase(s_erase), .expose(s_expose), .convert(s_convert),
    .ramp_code(s_ramp_code), .read_sel(s_read_sel), .pixel_data(s_pixel_data),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .frame_done(s_frame_done), .busy(s_busy)
  );

  typedef struct { int expo; int stalls; bit cont_next; } frame_t;

  frame_t        frm_q[$];
  logic [AB-1:0] pix_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pixel array and downstream sink model
  int ready_mode = 0;
  int bp_left = 0;
  always @(posedge clk) begin
    #1;
    if (reset && read_sel != '0 && !out_valid) begin
      pixel_data = AB'($urandom);
      pix_q.push_back(pixel_data);
    end else begin
      pixel_data = AB'($urandom);
    end
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin
        if (out_valid && read_sel == SEL2 && bp_left > 0) begin
          out_ready = 1'b0;
          bp_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: per-frame phase lengths, ramp shape, handshakes
  int c_erase, c_expose, c_conv, c_rd, c_pix, c_stall, frames_seen = 0;
  bit ramp_ok, stable_ok, excl_ok, hold_prev, pend_next = 1'b0, exp_next;
  logic [AB-1:0] held_data;
  logic [NP-1:0] held_sel;
  frame_t mon_f;

  function automatic void clr_frame();
    c_erase = 0; c_expose = 0; c_conv = 0; c_rd = 0; c_pix = 0; c_stall = 0;
    ramp_ok = 1'b1; stable_ok = 1'b1; excl_ok = 1'b1; hold_prev = 1'b0;
  endfunction

  initial clr_frame();

  always @(negedge clk) begin
    if (!reset) begin
      pix_q.delete();
      frm_q.delete();
      clr_frame();
      pend_next = 1'b0;
    end else begin
      if (pend_next) begin
        chk("after_done_erase", erase, exp_next);
        chk("after_done_busy", busy, exp_next);
        pend_next = 1'b0;
      end
      if ((int'(erase) + int'(expose) + int'(convert)) > 1 ||
          ((erase || expose || convert) && read_sel != '0)) excl_ok = 1'b0;
      if (erase || expose) begin
        if (ramp_code != '0) ramp_ok = 1'b0;
      end
      if (erase) c_erase++;
      if (expose) c_expose++;
      if (convert) begin
        if (ramp_code != AB'(c_conv)) ramp_ok = 1'b0;
        c_conv++;
      end else if (c_conv > 0 && ramp_code != {AB{1'b1}}) begin
        ramp_ok = 1'b0;
      end
      if (read_sel != '0) c_rd++;
      if (hold_prev && (!out_valid || out_data != held_data || read_sel != held_sel))
        stable_ok = 1'b0;
      hold_prev = out_valid && !out_ready;
      held_data = out_data;
      held_sel  = read_sel;
      if (out_valid && !out_ready) c_stall++;
      if (out_valid && out_ready) begin
        chk("pixel_expected", pix_q.size() != 0, 1);
        if (pix_q.size() != 0) chk("out_data", out_data, pix_q.pop_front());
        chk("read_sel_onehot", read_sel, longint'(1) << c_pix);
        c_pix++;
      end
      if (frame_done) begin
        chk("frame_done_expected", frm_q.size() != 0, 1);
        if (frm_q.size() != 0) begin
          mon_f = frm_q.pop_front();
          chk("erase_cycles", c_erase, EC);
          chk("expose_cycles", c_expose, mon_f.expo);
          chk("convert_cycles", c_conv, NCONV);
          chk("ramp_sequence_ok", ramp_ok, 1);
          chk("pixels_out", c_pix, NP);
          chk("read_cycles", c_rd, 2 * NP + c_stall);
          if (mon_f.stalls >= 0) chk("stall_cycles", c_stall, mon_f.stalls);
          chk("handshake_stable", stable_ok, 1);
          chk("phases_exclusive", excl_ok, 1);
          pend_next = 1'b1;
          exp_next  = mon_f.cont_next;
        end
        frames_seen++;
        clr_frame();
      end
    end
  end

  task automatic reset_vals(input string tag);
    chk({tag, "_erase"}, erase, 0);
    chk({tag, "_expose"}, expose, 0);
    chk({tag, "_convert"}, convert, 0);
    chk({tag, "_ramp"}, ramp_code, 0);
    chk({tag, "_read_sel"}, read_sel, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic issue(input int len, input int stalls);
    frame_t f;
    f.expo = (len == 0) ? 1 : len;
    f.stalls = stalls;
    f.cont_next = 1'b0;
    frm_q.push_back(f);
    expose_len = 16'(len);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit poke);
    int i = 0;
    while (i < 3000 && (busy || frm_q.size() != 0 || pend_next)) begin
      if (poke) begin
        start = convert ? 1'($urandom_range(0, 1)) : 1'b0;
        if (busy) expose_len = 16'($urandom);
      end
      tick(1);
      i++;
    end
    start = 1'b0;
    chk("idle_reached_busy", busy, 0);
    chk("frames_pending", frm_q.size(), 0);
  endtask

  task automatic small_sweep();
    int ce = 0, cx = 0, cc = 0, nh = 0, nd = 0;
    bit rok = 1'b1;
    logic [SAB-1:0] v;
    v = SAB'($urandom);
    s_pixel_data = v;
    s_expose_len = 16'd3;
    s_reset = 1'b1;
    tick(2);
    s_start = 1'b1;
    tick(1);
    s_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (s_erase) ce++;
      if (s_expose) cx++;
      if (s_convert) begin
        if (s_ramp_code != SAB'(cc)) rok = 1'b0;
        cc++;
      end
      if (s_out_valid && s_out_ready) begin
        nh++;
        chk("s_out_data", s_out_data, v);
        chk("s_read_sel", s_read_sel, 1);
      end
      if (s_frame_done) nd++;
      tick(1);
    end
    chk("s_erase_cycles", ce, 1);
    chk("s_expose_cycles", cx, 3);
    chk("s_convert_cycles", cc, 16);
    chk("s_ramp_ok", rok, 1);
    chk("s_pixels", nh, 1);
    chk("s_frame_done", nd, 1);
    chk("s_busy_end", s_busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int i, base, len;
    frame_t f;
    reset = 1'b0; start = 1'b0; continuous = 1'b0; expose_len = '0;
    s_reset = 1'b0; s_start = 1'b0; s_continuous = 1'b0; s_out_ready = 1'b1;
    s_expose_len = '0; s_pixel_data = '0;
    tick(3);
    reset_vals("por");
    small_sweep();

    reset = 1'b1;
    tick(6);
    chk("no_frame_without_start", busy, 0);

    // Single frame, out_ready always high
    ready_mode = 0;
    issue(10, 0);
    wait_idle(0);

    // Backpressure on pixel 2
    ready_mode = 1;
    bp_left = 7;
    issue(int'($urandom_range(1, 20)), 7);
    wait_idle(0);
    ready_mode = 0;

    // Zero exposure, length changed mid-expose
    issue(0, 0);
    for (i = 0; i < 50 && !expose; i++) tick(1);
    chk("saw_expose", expose, 1);
    expose_len = 16'd50;
    wait_idle(0);

    // Random frames with random backpressure and ignored start/expose_len
    ready_mode = 2;
    for (int k = 0; k < 4; k++) begin
      issue(int'($urandom_range(1, 40)), -1);
      wait_idle(1);
    end
    ready_mode = 0;

    // Continuous mode for three frames, dropped during the third convert
    base = frames_seen;
    len = int'($urandom_range(1, 30));
    for (int k = 0; k < 3; k++) begin
      f.expo = len; f.stalls = 0; f.cont_next = (k < 2);
      frm_q.push_back(f);
    end
    expose_len = 16'(len);
    continuous = 1'b1;
    for (i = 0; i < 3000 && !(frames_seen == base + 2 && convert); i++) tick(1);
    chk("cont_frame3_convert", convert, 1);
    continuous = 1'b0;
    wait_idle(0);
    chk("cont_frames_seen", frames_seen - base, 3);

    // Reset in the middle of convert
    issue(int'($urandom_range(1, 20)), -1);
    for (i = 0; i < 1000 && !(convert && ramp_code == AB'(100)); i++) tick(1);
    chk("saw_ramp_100", ramp_code, 100);
    reset = 1'b0;
    tick(1);
    reset_vals("rst_conv");
    tick(2);
    reset = 1'b1;
    tick(3);
    chk("idle_after_rst_conv", busy, 0);

    // Reset while a handshake is pending
    ready_mode = 3;
    issue(int'($urandom_range(1, 20)), -1);
    for (i = 0; i < 1000 && !out_valid; i++) tick(1);
    chk("saw_out_valid", out_valid, 1);
    tick(2);
    reset = 1'b0;
    tick(1);
    reset_vals("rst_xfer");
    ready_mode = 0;
    tick(2);
    reset = 1'b1;
    tick(3);
    chk("idle_after_rst_xfer", busy, 0);

    // Recovery frame
    issue(int'($urandom_range(1, 40)), 0);
    wait_idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
